// File: rtl/ps2_writer.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked shift of
// start/data/odd-parity/stop, then ack check. Lines are open-drain (driven 0 or released).
module ps2_writer #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  inout  logic       ps2_clk,
  inout  logic       ps2_data,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] INH_END  = TW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, SHIFT, ACK, RELEASE} state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t          state, state_nxt;
  logic            clk_oe, data_oe;
  logic [8:0]      shreg;
  logic [3:0]      bitcnt;
  logic [TW-1:0]   timer;
  logic            clk_sync_p0, clk_sync_p1, clk_prev_p2;
  logic            data_sync_p0, data_sync_p1;
  logic            fall, line_idle, accept, timer_hit;
  logic            done_nxt, err_nxt;

  assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
  assign ps2_data = data_oe ? 1'b0 : 1'bz;

  // Stage p0/p1: two-flop synchronizer; p2: previous synced clock for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      clk_prev_p2  <= 1'b1;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0  <= ps2_clk;
      clk_sync_p1  <= clk_sync_p0;
      clk_prev_p2  <= clk_sync_p1;
      data_sync_p0 <= ps2_data;
      data_sync_p1 <= data_sync_p0;
    end
  end

  assign fall      = clk_prev_p2 & ~clk_sync_p1;
  assign line_idle = clk_sync_p1 & data_sync_p1;
  assign timer_hit = (timer == TMO_LAST);
  // A start coinciding with the done/err pulse is dropped, not queued.
  assign accept    = (state == IDLE) && tx_start && !tx_done && !tx_err;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = INHIBIT;
      INHIBIT: if (timer == INH_END) state_nxt = SHIFT;
      SHIFT: begin
        if (fall && bitcnt == 4'd9) state_nxt = ACK;
        else if (err_nxt)           state_nxt = IDLE;
      end
      ACK: begin
        if (fall && !data_sync_p1) state_nxt = RELEASE;
        else if (err_nxt)          state_nxt = IDLE;
      end
      RELEASE: if (done_nxt || err_nxt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done_nxt = 1'b0;
    err_nxt  = 1'b0;
    case (state)
      SHIFT:   err_nxt = !fall && timer_hit;
      ACK:     err_nxt = fall ? data_sync_p1 : timer_hit;
      RELEASE: begin
        done_nxt = line_idle;
        err_nxt  = !line_idle && timer_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
      shreg   <= '0;
      bitcnt  <= '0;
      timer   <= '0;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
    end else begin
      tx_done <= done_nxt;
      tx_err  <= err_nxt;
      case (state)
        IDLE: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          if (accept) begin
            shreg  <= {odd_parity(tx_data), tx_data};
            busy   <= 1'b1;
            timer  <= '0;
            bitcnt <= '0;
            clk_oe <= 1'b1;
          end
        end
        INHIBIT: begin
          if (timer == INH_END) begin
            clk_oe <= 1'b0;
            timer  <= '0;
            bitcnt <= '0;
          end else begin
            timer <= timer + 1'b1;
            if (timer == INH_LAST) data_oe <= 1'b1;
          end
        end
        SHIFT: begin
          if (fall) begin
            bitcnt <= bitcnt + 1'b1;
            timer  <= '0;
            // Edges 1-9 present data then parity; edge 10 releases the line as the stop bit
            if (bitcnt < 4'd9) data_oe <= ~shreg[bitcnt];
            else               data_oe <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ACK: begin
          if (fall) timer <= '0;
          else      timer <= timer + 1'b1;
        end
        RELEASE: timer <= timer + 1'b1;
        default: ;
      endcase
      if (done_nxt || err_nxt) begin
        clk_oe  <= 1'b0;
        data_oe <= 1'b0;
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_writer.sv
// Bench for ps2_writer: a PS/2 device model clocks frames; a scoreboard queue holds the
// expected outcome (done/err) of each transfer and a monitor checks every pulse.
module tb_ps2_writer;

  localparam int INH = 8;
  localparam int TMO = 64;
  localparam int H   = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  wire        ps2_clk;
  wire        ps2_data;
  logic       busy, tx_done, tx_err;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_data);

  ps2_writer #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int err_cyc = 0;
  int exp_q[$];          // 1 = tx_done expected, 2 = tx_err expected
  logic prev_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every done/err pulse is compared against the scoreboard head
  always @(negedge clk) begin
    if (prev_pulse) check("pulse_width", int'(tx_done | tx_err), 0);
    prev_pulse <= tx_done | tx_err;
    if (tx_done || tx_err) begin
      if (tx_err) err_cyc <= cyc;
      if (exp_q.size() == 0)
        check("outcome_unexpected", (tx_done && !tx_err) ? 1 : (tx_err && !tx_done) ? 2 : 3, 0);
      else
        check("outcome", (tx_done && !tx_err) ? 1 : (tx_err && !tx_done) ? 2 : 3, exp_q.pop_front());
      check("busy_at_pulse", int'(busy), 0);
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device model: observes inhibit/RTS, clocks 'edges' falling edges, samples data in the high phase
  task automatic dev_frame(input logic [10:0] exp_bits, input int edges, input logic ack,
                           input logic chk_inh);
    int n;
    int i;
    logic [10:0] seen;
    n = 0;
    seen = '0;
    for (i = 0; i < 200; i++) begin
      if (ps2_clk === 1'b0 && ps2_data === 1'b1) n++;
      else if (ps2_data === 1'b0) break;
      @(negedge clk);
    end
    if (chk_inh) check("inhibit_len", n, INH);
    i = 0;
    while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("rts_seen", int'(i < 200), 1);
    repeat (4) @(negedge clk);
    for (int e = 1; e <= edges; e++) begin
      seen[e-1] = ps2_data;
      if (e == 11 && ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      last_fall_cyc = cyc;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    dev_data_low = 1'b0;
    if (edges == 11) check("frame_bits", int'(seen), int'(exp_bits));
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("idle_reached", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("clk_released", int'(ps2_clk), 1);
    check("data_released", int'(ps2_data), 1);
  endtask

  // Hand-computed odd parity: F4 (5 ones) ->0, FF ->1, 00 ->1, 01 ->0
  logic [7:0] vec_d[4] = '{8'hF4, 8'hFF, 8'h00, 8'h01};
  logic       vec_p[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    tx_start = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(tx_done), 0);
    check("rst_err", int'(tx_err), 0);
    check("rst_clk_line", int'(ps2_clk), 1);
    check("rst_data_line", int'(ps2_data), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(1);
      send(vec_d[k]);
      check("busy_set", int'(busy), 1);
      dev_frame({1'b1, vec_p[k], vec_d[k], 1'b0}, 11, 1'b1, k == 0);
      wait_idle();
    end

    // Missing ack: 0x5A has four ones, parity 1
    exp_q.push_back(2);
    send(8'h5A);
    dev_frame({1'b1, 1'b1, 8'h5A, 1'b0}, 11, 1'b0, 1'b0);
    wait_idle();

    // Timeout: 2 sync flops + 1 edge-register cycle + TMO cycles from the driven edge
    exp_q.push_back(2);
    send(8'hF4);
    dev_frame(11'h0, 4, 1'b1, 1'b0);
    wait_idle();
    check("timeout_latency", err_cyc - last_fall_cyc, TMO + 3);

    // A start pulse mid-frame must be ignored
    exp_q.push_back(1);
    send(8'hF4);
    fork
      dev_frame({1'b1, 1'b0, 8'hF4, 1'b0}, 11, 1'b1, 1'b0);
      begin
        repeat (60) @(negedge clk);
        tx_data = 8'hAA;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    wait_idle();
    repeat (50) @(negedge clk);
    check("no_late_start", int'(busy), 0);

    // Reset after edge 5 of 0x00: data bit 4 is 0 so the host is pulling data low
    send(8'h00);
    dev_frame(11'h0, 5, 1'b1, 1'b0);
    check("data_driven_pre_rst", int'(ps2_data), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_clk_line", int'(ps2_clk), 1);
    check("midrst_data_line", int'(ps2_data), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(tx_done), 0);
    check("midrst_err", int'(tx_err), 0);
    repeat (5) @(negedge clk);

    // 0xF5 has six ones, parity 1
    exp_q.push_back(1);
    send(8'hF5);
    dev_frame({1'b1, 1'b1, 8'hF5, 1'b0}, 11, 1'b1, 1'b1);
    wait_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
